// File: rtl/uart_rx_oversample.sv
// 16x-oversampled UART receiver: start-edge detect, mid-bit sampling, LSB-first data, stop check.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and a parity_error pulse.
module uart_rx_oversample #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk_board,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_error,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 busy
);

  localparam logic [3:0] MidTick  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LastTick = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 busy_q, busy_d;
  logic                 rx_meta_q, rx_sync_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_error_q, parity_error_d;
  logic                 parity_ok;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_ok = ~((^shreg_q) ^ par_bit_q);
`endif

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    data_d        = data_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d      = par_bit_q;
    parity_error_d = 1'b0;
`endif

    if (tick_16x) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      unique case (state_q)
        StIdle: begin
          tick_cnt_d = 4'd0;
          if (!rx_sync_q) begin
            state_d = StStart;
          end
        end
        StStart: begin
          // Re-check the line at mid start bit to reject glitches.
          if (tick_cnt_q == MidTick) begin
            tick_cnt_d = 4'd0;
            bit_idx_d  = 3'd0;
            state_d    = rx_sync_q ? StIdle : StData;
          end
        end
        StData: begin
          if (tick_cnt_q == LastTick) begin
            shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
            if (bit_idx_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick_cnt_q == LastTick) begin
            par_bit_d = rx_sync_q;
            state_d   = StStop;
          end
        end
`endif
        StStop: begin
          if (tick_cnt_q == LastTick) begin
            if (rx_sync_q) begin
              state_d = StIdle;
`ifdef UART_RX_PARITY_EN
              if (parity_ok) begin
                data_d       = shreg_q;
                data_valid_d = 1'b1;
              end else begin
                parity_error_d = 1'b1;
              end
`else
              data_d       = shreg_q;
              data_valid_d = 1'b1;
`endif
            end else begin
              frame_error_d = 1'b1;
              state_d       = StWaitHigh;
            end
          end
        end
        StWaitHigh: begin
          // Hold off until the line returns high so a break is not read as a start bit.
          tick_cnt_d = 4'd0;
          if (rx_sync_q) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d    = StIdle;
          tick_cnt_d = 4'd0;
        end
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_board or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      tick_cnt_q    <= 4'd0;
      bit_idx_q     <= 3'd0;
      shreg_q       <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bit_q      <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
`ifdef UART_RX_PARITY_EN
      par_bit_q      <= par_bit_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_error_q;
`endif

  valid_error_exclusive_a: assert property (
    @(posedge clk_board) disable iff (reset) !(data_valid_q && frame_error_q)
  );

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: tick_16x every 4 clocks, 16-tick-wide serial bits.
// Hand-computed expectations; compile with UART_RX_PARITY_EN to also exercise the parity path.
module tb_uart_rx_oversample;

  logic       clk_board = 1'b0;
  logic       reset;
  logic       tick_16x;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
  logic       flip_par = 1'b0;
  int         pe_cnt = 0;
  logic       prev_pe = 1'b0;
  // Start-edge to data_valid: detection one tick after the fall, then 16*(1+8)+8+16 ticks.
  localparam int ExpLat = 676;
`else
  localparam int ExpLat = 612;
`endif

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  logic       prev_dv = 1'b0;
  logic       prev_fe = 1'b0;
  logic [7:0] rx_log[$];

  uart_rx_oversample #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) u_dut (
    .clk_board   (clk_board),
    .reset       (reset),
    .tick_16x    (tick_16x),
    .rx          (rx),
    .data        (data),
    .data_valid  (data_valid),
    .frame_error (frame_error),
`ifdef UART_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .busy        (busy)
  );

  always #5 clk_board = ~clk_board;

  initial begin
    tick_16x = 1'b0;
    forever begin
      repeat (3) @(negedge clk_board);
      tick_16x = 1'b1;
      @(negedge clk_board);
      tick_16x = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk_board);
      cyc++;
      #1;
      if (data_valid) begin
        check_eq("dv_width", 32'(prev_dv), 32'd0);
        check_eq("dv_latency", 32'(cyc - start_cyc), 32'(ExpLat));
        rx_log.push_back(data);
        dv_cnt++;
      end
      if (frame_error) begin
        check_eq("fe_width", 32'(prev_fe), 32'd0);
        fe_cnt++;
      end
      if (data_valid || frame_error) begin
        check_eq("dv_fe_excl", 32'(data_valid & frame_error), 32'd0);
      end
`ifdef UART_RX_PARITY_EN
      if (parity_error) begin
        check_eq("pe_width", 32'(prev_pe), 32'd0);
        check_eq("pe_dv_excl", 32'(data_valid), 32'd0);
        pe_cnt++;
      end
      prev_pe = parity_error;
`endif
      prev_dv = data_valid;
      prev_fe = frame_error;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_ticks(input int n);
    repeat (4 * n) @(negedge clk_board);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ flip_par);
`endif
    send_bit(stop);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk_board);
    check_eq("rst_data", 32'(data), 32'h00);
    check_eq("rst_dv", 32'(data_valid), 32'd0);
    check_eq("rst_fe", 32'(frame_error), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    // Align stimulus to the negedge right after a tick edge.
    @(posedge clk_board iff tick_16x);
    @(negedge clk_board);
    wait_ticks(4);

    // Clean frame.
    send_frame(8'hA5, 1'b1);
    wait_ticks(4);
    check_eq("a5_dv_cnt", 32'(dv_cnt), 32'd1);
    check_eq("a5_log", 32'(rx_log[0]), 32'hA5);
    check_eq("a5_data", 32'(data), 32'hA5);
    check_eq("a5_fe_cnt", 32'(fe_cnt), 32'd0);
    check_eq("a5_busy", 32'(busy), 32'd0);

    // Bad stop bit followed by a 40-tick break.
    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    check_eq("brk_fe_cnt", 32'(fe_cnt), 32'd1);
    check_eq("brk_dv_cnt", 32'(dv_cnt), 32'd1);
    check_eq("brk_data", 32'(data), 32'hA5);
    check_eq("brk_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_ticks(4);
    check_eq("brk_busy_end", 32'(busy), 32'd0);
    wait_ticks(160);
    check_eq("brk_no_dv", 32'(dv_cnt), 32'd1);
    check_eq("brk_no_fe", 32'(fe_cnt), 32'd1);

    // Short glitch, then a good frame.
    rx = 1'b0;
    wait_ticks(3);
    check_eq("gl_busy", 32'(busy), 32'd1);
    wait_ticks(1);
    rx = 1'b1;
    wait_ticks(8);
    check_eq("gl_busy_end", 32'(busy), 32'd0);
    check_eq("gl_dv_cnt", 32'(dv_cnt), 32'd1);
    check_eq("gl_fe_cnt", 32'(fe_cnt), 32'd1);
    send_frame(8'h3C, 1'b1);
    wait_ticks(4);
    check_eq("3c_dv_cnt", 32'(dv_cnt), 32'd2);
    check_eq("3c_log", 32'(rx_log[1]), 32'h3C);
    check_eq("3c_data", 32'(data), 32'h3C);

    // Reset after three data bits of 0xFF.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    rx    = 1'b1;
    #1;
    check_eq("mid_rst_data", 32'(data), 32'h00);
    check_eq("mid_rst_dv", 32'(data_valid), 32'd0);
    check_eq("mid_rst_fe", 32'(frame_error), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    wait_ticks(2);
    reset = 1'b0;
    wait_ticks(4);
    check_eq("mid_rst_no_dv", 32'(dv_cnt), 32'd2);
    send_frame(8'h0F, 1'b1);
    wait_ticks(4);
    check_eq("0f_dv_cnt", 32'(dv_cnt), 32'd3);
    check_eq("0f_log", 32'(rx_log[2]), 32'h0F);
    check_eq("0f_data", 32'(data), 32'h0F);

    // Back-to-back frames, no idle gap.
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    wait_ticks(4);
    check_eq("b2b_dv_cnt", 32'(dv_cnt), 32'd5);
    check_eq("b2b_first", 32'(rx_log[3]), 32'h55);
    check_eq("b2b_second", 32'(rx_log[4]), 32'hAA);
    check_eq("b2b_data", 32'(data), 32'hAA);
    check_eq("b2b_fe_cnt", 32'(fe_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
    flip_par = 1'b1;
    send_frame(8'h01, 1'b1);
    wait_ticks(4);
    check_eq("par_bad_pe_cnt", 32'(pe_cnt), 32'd1);
    check_eq("par_bad_dv_cnt", 32'(dv_cnt), 32'd5);
    check_eq("par_bad_data", 32'(data), 32'hAA);
    flip_par = 1'b0;
    send_frame(8'h01, 1'b1);
    wait_ticks(4);
    check_eq("par_ok_pe_cnt", 32'(pe_cnt), 32'd1);
    check_eq("par_ok_dv_cnt", 32'(dv_cnt), 32'd6);
    check_eq("par_ok_data", 32'(data), 32'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
